dm_port_arbiter: RTL and testbench
==================================

// Module: dm_port_arbiter
// PURPOSE
//  Shares the single-port data-memory RAM (12-bit word address, 1-cycle registered read) between two requesters:
//  m0 = pipeline MEM stage, m1 = debug/DMA loader. Grants one access per cycle.
//  Builds byte-lane write enables for sb/sh/sw and aligns/extends load data for lb/lbu/lh/lhu/lw.
//  Returns every accepted access as a response pulse one cycle later.
// PARAMETERS
//  DEPTH_WORDS  3072  implemented RAM words; word index >= DEPTH_WORDS is out of range
//  FIXED_PRIO   0     0 = round-robin between m0/m1; 1 = m0 always wins
// PORTS
//  clk          in   1   clock; RAM shares this clock
//  rst_n        in   1   asynchronous active-low reset
//  mX_req       in   1   X=0,1: access request, held until mX_gnt
//  mX_we        in   1   1 = store, 0 = load
//  mX_size      in   2   00 byte, 01 half, 10 word, 11 illegal
//  mX_signed    in   1   load sign-extend (ignored for word/store)
//  mX_addr      in   32  byte address
//  mX_wdata     in   32  store data, right-justified
//  mX_gnt       out  1   request accepted this cycle (combinational)
//  mX_rvalid    out  1   response for mX's last accepted access
//  mX_rdata     out  32  aligned/extended load data; 0 for stores and errors
//  mX_err       out  1   qualifies rvalid: misaligned, size=11 or out of range
//  ram_en       out  1   RAM enable (comb.)
//  ram_we       out  4   RAM byte-lane write enables (comb.)
//  ram_addr     out  12  RAM word address = addr[13:2] of granted request
//  ram_din      out  32  RAM write data
//  ram_dout     in   32  RAM read data, valid the cycle after the address edge
// BEHAVIOUR
//  Reset (rst_n low, async): gnt=0, rvalid=0, err=0, rdata=0, ram_en=0, ram_we=0; rr pointer -> m0 next; pending response cleared.
//  Arbitration, per cycle: one req -> grant it; both -> FIXED_PRIO=1: m0; else master not granted last; pointer updates only on a grant.
//  Error check on winner: size=11; half with addr[0]=1; word with addr[1:0]!=0; addr[31:14]!=0 or addr[13:2]>=DEPTH_WORDS.
//  Erroring request is still granted (consumed) but ram_en=0, ram_we=0; its response carries err=1.
//  Legal granted access: ram_en=1, ram_addr=addr[13:2]; load: ram_we=0.
//  Store lanes, off=addr[1:0]: byte -> ram_we=1<<off, ram_din={4{wdata[7:0]}}; half -> ram_we=off[1]?1100:0011,
//   ram_din={2{wdata[15:0]}}; word -> 1111, ram_din=wdata. RAM writes partial lanes from din low bits; replication satisfies both.
//  No grant: ram_en=0, ram_we=0; ram_addr/ram_din hold last driven value (RAM reads ram_addr every cycle regardless of en).
//  Response register, loaded on every grant edge: owner, we, size, signed, off, err. Cleared when no grant.
//  Latency: grant in cycle N -> owner's rvalid=1 exactly in cycle N+1, single-cycle pulse; other master's rvalid=0.
//  Load data in N+1 from ram_dout: byte = dout[8*off+:8], half = dout[16*off[1]+:16], word = dout;
//   signed -> sign-extend, else zero-extend. Stores and errors: rdata=0.
//  Back-to-back: new grant allowed every cycle; responses stream 1/cycle in grant order.
//  Read-after-write, same word, consecutive cycles: read returns new data (RAM written at edge N, read at N+1).
//  Requester dropping req without gnt is legal; nothing is recorded.
//  Reset asserted mid-access: pending rvalid suppressed; a RAM write already clocked is not undone.
// TESTING
//  1 m0 sw 0xDEADBEEF @0x100, then lw @0x100 -> ram_we=1111 addr=0x040; rvalid cycle N+1; rdata=0xDEADBEEF.
//  2 sb 0x80 @0x103, lb @0x103 -> ram_we=1000, din=0x80808080; lb rdata=0xFFFFFF80; lbu rdata=0x00000080.
//  3 sh 0x1234 @0x102; lhu @0x102 -> ram_we=1100; rdata=0x00001234; lh of 0x8001 -> 0xFFFF8001.
//  4 m0,m1 req continuously for 6 cycles, FIXED_PRIO=0 -> gnt alternates m0,m1,m0..., rvalid follows 1 cycle later to owner.
//  5 lw @0x102, sh @0x101, lw @0x3000 (word 3072) -> gnt=1, ram_en=0, rvalid+err=1, rdata=0, RAM unchanged.
//  6 rst_n low in cycle after load grant -> rvalid never asserts; after release, first tie goes to m0.

Source files
------------

// File: rtl/dm_port_arbiter_if.sv
// One requester port of the data-memory arbiter: request fields in, grant and response out.
// Handshake: a master holds req with stable fields until gnt; one response pulse (rvalid) follows each gnt.
interface dm_port_arbiter_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (output req, we, size, sext, addr, wdata,
                    input  gnt, rvalid, rdata, err);
    modport slave  (input  req, we, size, sext, addr, wdata,
                    output gnt, rvalid, rdata, err);
endinterface

// File: rtl/dm_port_arbiter.sv
// Two-master arbiter in front of the single-port data RAM: grants one access per cycle,
// builds byte-lane strobes for stores and aligns/extends load data on the following cycle.
module dm_port_arbiter #(
    parameter int DEPTH_WORDS = 3072,
    parameter bit FIXED_PRIO  = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    dm_port_arbiter_if.slave m0,
    dm_port_arbiter_if.slave m1,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [11:0] ram_addr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout,
    output logic        dbg_last_gnt
);

    localparam logic [0:0]  LAST_M0   = 1'b0;
    localparam logic [0:0]  LAST_M1   = 1'b1;
    localparam logic [12:0] DEPTH_LIM = 13'(DEPTH_WORDS);

    logic [0:0]  last_q;
    logic        pick_m1;
    logic        gnt_any;
    logic        legal;
    logic        w_we;
    logic [1:0]  w_size;
    logic        w_sext;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [1:0]  w_off;
    logic [11:0] w_word;
    logic        w_err;
    logic [3:0]  lanes;
    logic [31:0] din_n;
    logic [11:0] addr_q;
    logic [31:0] din_q;

    logic        rsp_valid;
    logic        rsp_owner;
    logic        rsp_we;
    logic [1:0]  rsp_size;
    logic        rsp_sext;
    logic [1:0]  rsp_off;
    logic        rsp_err;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rdata_n;

    assign dbg_last_gnt = last_q;

    // On a tie the master that was not granted last wins unless m0 has fixed priority.
    always_comb begin
        pick_m1 = 1'b0;
        if (m0.req && m1.req) begin
            pick_m1 = FIXED_PRIO ? 1'b0 : (last_q == LAST_M0);
        end else begin
            pick_m1 = m1.req;
        end
    end

    assign gnt_any = rst_n & (m0.req | m1.req);
    assign m0.gnt  = gnt_any & ~pick_m1;
    assign m1.gnt  = gnt_any & pick_m1;

    assign w_we    = pick_m1 ? m1.we    : m0.we;
    assign w_size  = pick_m1 ? m1.size  : m0.size;
    assign w_sext  = pick_m1 ? m1.sext  : m0.sext;
    assign w_addr  = pick_m1 ? m1.addr  : m0.addr;
    assign w_wdata = pick_m1 ? m1.wdata : m0.wdata;
    assign w_off   = w_addr[1:0];
    assign w_word  = w_addr[13:2];

    assign w_err = (w_size == 2'b11)
                 | ((w_size == 2'b01) & w_off[0])
                 | ((w_size == 2'b10) & (|w_off))
                 | (|w_addr[31:14])
                 | ({1'b0, w_word} >= DEPTH_LIM);

    assign legal = gnt_any & ~w_err;

    // Store data is replicated so every enabled lane sees the right bytes.
    always_comb begin
        lanes = 4'b0000;
        din_n = w_wdata;
        case (w_size)
            2'b00: begin
                lanes = 4'b0001 << w_off;
                din_n = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                lanes = w_off[1] ? 4'b1100 : 4'b0011;
                din_n = {2{w_wdata[15:0]}};
            end
            default: begin
                lanes = 4'b1111;
                din_n = w_wdata;
            end
        endcase
    end

    assign ram_en   = legal;
    assign ram_we   = (legal && w_we) ? lanes : 4'b0000;
    assign ram_addr = legal ? w_word : addr_q;
    assign ram_din  = legal ? din_n : din_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q    <= LAST_M1;
            addr_q    <= '0;
            din_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_owner <= 1'b0;
            rsp_we    <= 1'b0;
            rsp_size  <= 2'b00;
            rsp_sext  <= 1'b0;
            rsp_off   <= 2'b00;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= gnt_any;
            if (gnt_any) begin
                last_q    <= pick_m1 ? LAST_M1 : LAST_M0;
                rsp_owner <= pick_m1;
                rsp_we    <= w_we;
                rsp_size  <= w_size;
                rsp_sext  <= w_sext;
                rsp_off   <= w_off;
                rsp_err   <= w_err;
            end
            if (legal) begin
                addr_q <= w_word;
                din_q  <= din_n;
            end
        end
    end

    always_comb begin
        case (rsp_off)
            2'd0:    rd_byte = ram_dout[7:0];
            2'd1:    rd_byte = ram_dout[15:8];
            2'd2:    rd_byte = ram_dout[23:16];
            default: rd_byte = ram_dout[31:24];
        endcase
        rd_half = rsp_off[1] ? ram_dout[31:16] : ram_dout[15:0];
        rdata_n = '0;
        if (rsp_valid && !rsp_we && !rsp_err) begin
            case (rsp_size)
                2'b00:   rdata_n = {{24{rsp_sext & rd_byte[7]}}, rd_byte};
                2'b01:   rdata_n = {{16{rsp_sext & rd_half[15]}}, rd_half};
                default: rdata_n = ram_dout;
            endcase
        end
    end

    assign m0.rvalid = rsp_valid & ~rsp_owner;
    assign m1.rvalid = rsp_valid & rsp_owner;
    assign m0.rdata  = m0.rvalid ? rdata_n : '0;
    assign m1.rdata  = m1.rvalid ? rdata_n : '0;
    assign m0.err    = m0.rvalid & rsp_err;
    assign m1.err    = m1.rvalid & rsp_err;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: byte-addressed reference memory and arbitration model,
// directed scenarios followed by randomized two-master traffic.
module tb_dm_port_arbiter;
  localparam int DEPTH = 3072;

  typedef struct {
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dm_port_arbiter_if m0_if();
  dm_port_arbiter_if m1_if();
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic        dbg_last_gnt;

  dm_port_arbiter #(.DEPTH_WORDS(DEPTH), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .m0(m0_if), .m1(m1_if),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .dbg_last_gnt(dbg_last_gnt)
  );

  // RAM environment: byte-lane writes, registered read of ram_addr every cycle
  logic [31:0] ram [0:4095];
  always @(posedge clk) begin
    if (ram_en) begin
      for (int l = 0; l < 4; l++)
        if (ram_we[l]) ram[ram_addr][8*l +: 8] <= ram_din[8*l +: 8];
    end
    ram_dout <= ram[ram_addr];
  end

  // reference model state
  logic [7:0]  ref_mem [0:16383];
  req_t        pend [2];
  logic        rr_m1_last;
  logic        er_valid;
  logic        er_owner;
  logic        er_err;
  logic [31:0] er_rdata;
  logic        hold_valid;
  logic [11:0] hold_addr;

  // captured observations for directed checks
  logic [3:0]  cap_we;
  logic [31:0] cap_din;
  logic        cap_en;
  logic        cap_g0;
  logic [31:0] cap_rdata;
  logic        cap_err;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s obs=%h want=%h at %0t", tag, obs, want, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic is_err(input req_t r);
    if (r.size == 2'd3) return 1'b1;
    if ((r.addr % nbytes(r.size)) != 0) return 1'b1;
    if (r.addr >= 32'h4000) return 1'b1;
    if ((r.addr / 4) >= DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] load_val(input req_t r);
    logic [31:0] v;
    int n;
    v = '0;
    n = nbytes(r.size);
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(r.addr) + i];
    if (r.sext && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  function automatic req_t mk(input logic we, input logic [1:0] size, input logic sext,
                              input logic [31:0] addr, input logic [31:0] wdata);
    req_t r;
    r.req = 1'b1; r.we = we; r.size = size; r.sext = sext; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int k;
    logic [31:0] a;
    k = $urandom_range(0, 15);
    r.req   = 1'b1;
    r.we    = 1'($urandom_range(0, 1));
    r.size  = (k < 5) ? 2'd0 : (k < 10) ? 2'd1 : (k < 15) ? 2'd2 : 2'd3;
    r.sext  = 1'($urandom_range(0, 1));
    r.wdata = $urandom();
    case ($urandom_range(0, 9))
      0:       a = (32'd3068 + 32'($urandom_range(0, 7))) * 4;
      1:       a = {18'($urandom_range(1, 262143)), 14'($urandom_range(0, 16383))};
      default: a = (32'h40 + 32'($urandom_range(0, 7))) * 4;
    endcase
    a[1:0] = 2'($urandom_range(0, 3));
    if ($urandom_range(0, 1) == 0) begin
      if (r.size == 2'd2) a[1:0] = 2'd0;
      if (r.size == 2'd1) a[0] = 1'b0;
    end
    r.addr = a;
    return r;
  endfunction

  // driver
  task automatic drive_ports();
    m0_if.req = pend[0].req; m0_if.we = pend[0].we; m0_if.size = pend[0].size;
    m0_if.sext = pend[0].sext; m0_if.addr = pend[0].addr; m0_if.wdata = pend[0].wdata;
    m1_if.req = pend[1].req; m1_if.we = pend[1].we; m1_if.size = pend[1].size;
    m1_if.sext = pend[1].sext; m1_if.addr = pend[1].addr; m1_if.wdata = pend[1].wdata;
  endtask

  task automatic rand_traffic();
    for (int m = 0; m < 2; m++) begin
      if (pend[m].req) begin
        if ($urandom_range(0, 15) == 0) pend[m].req = 1'b0;
      end else if ($urandom_range(0, 3) != 0) begin
        pend[m] = rand_req();
      end
    end
  endtask

  // one cycle: drive, compare against model, advance model
  task automatic step(input logic allow_rand);
    logic g0, g1, e_err;
    req_t w;
    logic [3:0] e_we;
    logic [31:0] e_din;
    int n, off;
    @(negedge clk);
    if (allow_rand) rand_traffic();
    drive_ports();
    #1;
    g0 = 1'b0; g1 = 1'b0;
    if (pend[0].req && pend[1].req) begin
      if (rr_m1_last) g0 = 1'b1; else g1 = 1'b1;
    end else begin
      g0 = pend[0].req; g1 = pend[1].req;
    end
    check("gnt0", m0_if.gnt, g0);
    check("gnt1", m1_if.gnt, g1);
    check("rvalid0", m0_if.rvalid, er_valid && !er_owner);
    check("rvalid1", m1_if.rvalid, er_valid && er_owner);
    if (er_valid) begin
      cap_rdata = er_owner ? m1_if.rdata : m0_if.rdata;
      cap_err   = er_owner ? m1_if.err : m0_if.err;
      check("rdata", cap_rdata, er_rdata);
      check("err", cap_err, er_err);
    end
    er_valid = 1'b0;
    cap_g0 = m0_if.gnt;
    cap_en = ram_en;
    cap_we = ram_we;
    cap_din = ram_din;
    if (g0 || g1) begin
      w = g1 ? pend[1] : pend[0];
      e_err = is_err(w);
      check("ram_en", ram_en, !e_err);
      e_we = '0;
      e_din = '0;
      if (!e_err) begin
        n = nbytes(w.size);
        off = int'(w.addr % 4);
        for (int i = 0; i < n; i++) e_we[(off + i) % 4] = 1'b1;
        for (int l = 0; l < 4; l++) e_din[8*l +: 8] = w.wdata[8*(l % n) +: 8];
        check("ram_addr", ram_addr, w.addr / 4);
        check("ram_we", ram_we, w.we ? e_we : 4'b0000);
        if (w.we) check("ram_din", ram_din, e_din);
        hold_valid = 1'b1;
        hold_addr = 12'(w.addr / 4);
      end else begin
        check("ram_we_err", ram_we, 4'b0000);
      end
      er_valid = 1'b1;
      er_owner = g1;
      er_err   = e_err;
      er_rdata = (w.we || e_err) ? 32'd0 : load_val(w);
      if (w.we && !e_err)
        for (int i = 0; i < nbytes(w.size); i++) ref_mem[int'(w.addr) + i] = w.wdata[8*i +: 8];
      rr_m1_last = g1;
      pend[int'(g1)].req = 1'b0;
    end else begin
      check("ram_en_idle", ram_en, 1'b0);
      check("ram_we_idle", ram_we, 4'b0000);
      if (hold_valid) check("ram_addr_hold", ram_addr, hold_addr);
    end
  endtask

  task automatic run_pending();
    int n = 0;
    while ((pend[0].req || pend[1].req) && n < 20) begin
      step(1'b0);
      n++;
    end
    check("drain_timeout", {30'd0, pend[0].req, pend[1].req}, 32'd0);
    step(1'b0);
  endtask

  task automatic model_reset();
    rr_m1_last = 1'b1;
    er_valid = 1'b0;
    hold_valid = 1'b0;
  endtask

  logic [31:0] wv;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      wv = $urandom();
      ram[i] = wv;
      for (int k = 0; k < 4; k++) ref_mem[4*i + k] = wv[8*k +: 8];
    end
    pend[0] = mk(1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
    pend[1] = mk(1'b0, 2'd2, 1'b0, 32'h104, 32'd0);
    model_reset();
    drive_ports();

    // reset with both requests asserted: nothing granted, no response
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt0", m0_if.gnt, 1'b0);
    check("rst_gnt1", m1_if.gnt, 1'b0);
    check("rst_rvalid0", m0_if.rvalid, 1'b0);
    check("rst_rvalid1", m1_if.rvalid, 1'b0);
    check("rst_rdata0", m0_if.rdata, 32'd0);
    check("rst_err0", m0_if.err, 1'b0);
    check("rst_ram_en", ram_en, 1'b0);
    check("rst_ram_we", ram_we, 4'b0000);
    pend[0].req = 1'b0;
    pend[1].req = 1'b0;
    drive_ports();
    rst_n = 1'b1;

    // 1: sw / lw
    pend[0] = mk(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
    step(1'b0);
    check("t1_sw_we", cap_we, 4'b1111);
    pend[0] = mk(1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
    run_pending();
    check("t1_lw", cap_rdata, 32'hDEADBEEF);

    // 2: sb / lb / lbu
    pend[0] = mk(1'b1, 2'd0, 1'b0, 32'h103, 32'h80);
    step(1'b0);
    check("t2_sb_we", cap_we, 4'b1000);
    check("t2_sb_din", cap_din, 32'h80808080);
    pend[0] = mk(1'b0, 2'd0, 1'b1, 32'h103, 32'd0);
    run_pending();
    check("t2_lb", cap_rdata, 32'hFFFFFF80);
    pend[0] = mk(1'b0, 2'd0, 1'b0, 32'h103, 32'd0);
    run_pending();
    check("t2_lbu", cap_rdata, 32'h00000080);

    // 3: sh / lhu / lh
    pend[1] = mk(1'b1, 2'd1, 1'b0, 32'h102, 32'h1234);
    step(1'b0);
    check("t3_sh_we", cap_we, 4'b1100);
    pend[1] = mk(1'b0, 2'd1, 1'b0, 32'h102, 32'd0);
    run_pending();
    check("t3_lhu", cap_rdata, 32'h00001234);
    pend[1] = mk(1'b1, 2'd1, 1'b0, 32'h102, 32'h8001);
    run_pending();
    pend[1] = mk(1'b0, 2'd1, 1'b1, 32'h102, 32'd0);
    run_pending();
    check("t3_lh", cap_rdata, 32'hFFFF8001);

    // 4: both masters requesting continuously
    for (int i = 0; i < 6; i++) begin
      for (int m = 0; m < 2; m++)
        if (!pend[m].req) pend[m] = mk(1'b0, 2'd2, 1'b0, 32'h100 + 32'(4*m), 32'd0);
      step(1'b0);
    end
    run_pending();

    // 5: error accesses
    pend[0] = mk(1'b0, 2'd2, 1'b0, 32'h102, 32'd0);
    step(1'b0);
    check("t5_lw_mis_en", cap_en, 1'b0);
    step(1'b0);
    check("t5_lw_mis_err", cap_err, 1'b1);
    check("t5_lw_mis_rdata", cap_rdata, 32'd0);
    pend[0] = mk(1'b1, 2'd1, 1'b0, 32'h101, 32'hFFFF);
    step(1'b0);
    check("t5_sh_mis_we", cap_we, 4'b0000);
    step(1'b0);
    check("t5_sh_mis_err", cap_err, 1'b1);
    check("t5_ram_kept", ram[12'h040], {ref_mem[32'h103], ref_mem[32'h102], ref_mem[32'h101], ref_mem[32'h100]});
    pend[0] = mk(1'b0, 2'd2, 1'b0, 32'h3000, 32'd0);
    step(1'b0);
    check("t5_oor_en", cap_en, 1'b0);
    step(1'b0);
    check("t5_oor_err", cap_err, 1'b1);

    // 6: reset in the cycle after a load grant
    pend[0] = mk(1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
    step(1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_rvalid0", m0_if.rvalid, 1'b0);
    pend[0] = mk(1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
    pend[1] = mk(1'b0, 2'd2, 1'b0, 32'h104, 32'd0);
    drive_ports();
    @(negedge clk);
    #1;
    check("t6_rvalid0_hold", m0_if.rvalid, 1'b0);
    check("t6_gnt_in_rst", {31'd0, m0_if.gnt | m1_if.gnt}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0);
    check("t6_tie_m0", cap_g0, 1'b1);
    run_pending();

    // randomized traffic
    for (int i = 0; i < 600; i++) step(1'b1);
    run_pending();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
